// File: rtl/kgp_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kgp_alu_pkg
// Brief    : Opcodes, FSM state encoding and width defaults for the execute stage
// Revision : 1.0
// ============================================================================
package kgp_alu_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int SHAMT_W_DEF = 5;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] opc);
        return (opc == OP_SLL) || (opc == OP_SRL) || (opc == OP_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_addsub.sv
`default_nettype none
// ============================================================================
// Module   : alu_addsub
// Brief    : Combinational adder/subtractor with carry/borrow and overflow
// Revision : 1.0
// ============================================================================
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_full;

    // Subtraction as a + ~b + 1; borrow is the inverted carry out.
    assign w_b_eff  = sub ? ~b : b;
    assign w_full   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, sub};
    assign sum      = w_full[WIDTH-1:0];
    assign carry    = sub ? ~w_full[WIDTH] : w_full[WIDTH];
    assign overflow = sub ? ((a[WIDTH-1] != b[WIDTH-1]) && (w_full[WIDTH-1] != a[WIDTH-1]))
                          : ((a[WIDTH-1] == b[WIDTH-1]) && (w_full[WIDTH-1] != a[WIDTH-1]));

endmodule
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_stage
// Brief    : Registered ALU execute stage; single-cycle logic/arith, 1-bit/cycle shifts
// Revision : 1.0
// ============================================================================
module alu_exec_stage
    import kgp_alu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               flag_c,
    output logic               flag_z,
    output logic               flag_s,
    output logic               flag_v,
    output logic               illegal,
    output logic               busy
);

    state_t             r_state, w_next_state;
    logic [WIDTH-1:0]   r_work, r_result;
    logic [SHAMT_W-1:0] r_cnt;
    logic [3:0]         r_op;
    logic               r_fill;
    logic               r_c, r_z, r_s, r_v, r_illegal;

    logic               w_accept, w_in_shift, w_last_step;
    logic [WIDTH-1:0]   w_sum;
    logic               w_carry, w_ovf;
    logic [WIDTH-1:0]   w_step_src, w_step_res;
    logic [3:0]         w_step_op;
    logic               w_step_fill, w_step_c;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_c, w_alu_v, w_alu_ill;
    logic               w_load;
    logic [WIDTH-1:0]   w_load_res;
    logic               w_load_c, w_load_v, w_load_ill;

    assign in_ready    = (r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_in_shift  = is_shift(op) && (shamt != '0);
    assign w_last_step = (r_state == ST_SHIFT) && (r_cnt == SHAMT_W'(1));

    assign out_valid = (r_state == ST_HOLD);
    assign busy      = (r_state == ST_SHIFT);
    assign result    = r_result;
    assign flag_c    = r_c;
    assign flag_z    = r_z;
    assign flag_s    = r_s;
    assign flag_v    = r_v;
    assign illegal   = r_illegal;

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a        (a),
        .b        (b),
        .sub      (op == OP_SUB),
        .sum      (w_sum),
        .carry    (w_carry),
        .overflow (w_ovf)
    );

    // One shift step: the first step works on the incoming operand, later ones on r_work.
    always_comb begin
        w_step_src  = (r_state == ST_SHIFT) ? r_work : a;
        w_step_op   = (r_state == ST_SHIFT) ? r_op   : op;
        w_step_fill = (r_state == ST_SHIFT) ? r_fill : a[WIDTH-1];
        w_step_res  = {w_step_fill, w_step_src[WIDTH-1:1]};
        w_step_c    = w_step_src[0];
        case (w_step_op)
            OP_SLL: begin
                w_step_res = {w_step_src[WIDTH-2:0], 1'b0};
                w_step_c   = w_step_src[WIDTH-1];
            end
            OP_SRL: w_step_res = {1'b0, w_step_src[WIDTH-1:1]};
            default: ;
        endcase
    end

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        w_alu_ill = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                w_alu_res = w_sum;
                w_alu_c   = w_carry;
                w_alu_v   = w_ovf;
            end
            OP_AND: w_alu_res = a & b;
            OP_OR:  w_alu_res = a | b;
            OP_XOR: w_alu_res = a ^ b;
            OP_NOT: w_alu_res = ~a;
            OP_SLL, OP_SRL, OP_SRA: w_alu_res = a;
            default: w_alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_load     = 1'b0;
        w_load_res = w_alu_res;
        w_load_c   = w_alu_c;
        w_load_v   = w_alu_v;
        w_load_ill = w_alu_ill;
        if (w_accept) begin
            if (w_in_shift) begin
                w_load     = (shamt == SHAMT_W'(1));
                w_load_res = w_step_res;
                w_load_c   = w_step_c;
                w_load_v   = 1'b0;
                w_load_ill = 1'b0;
            end else begin
                w_load = 1'b1;
            end
        end else if (w_last_step) begin
            w_load     = 1'b1;
            w_load_res = w_step_res;
            w_load_c   = w_step_c;
            w_load_v   = 1'b0;
            w_load_ill = 1'b0;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (w_accept) begin
                    w_next_state = (w_in_shift && (shamt != SHAMT_W'(1))) ? ST_SHIFT : ST_HOLD;
                end else if ((r_state == ST_HOLD) && out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == SHAMT_W'(1)) begin
                    w_next_state = ST_HOLD;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work    <= '0;
            r_cnt     <= '0;
            r_op      <= 4'd0;
            r_fill    <= 1'b0;
            r_result  <= '0;
            r_c       <= 1'b0;
            r_z       <= 1'b0;
            r_s       <= 1'b0;
            r_v       <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (w_accept && w_in_shift) begin
                r_work <= w_step_res;
                r_cnt  <= shamt - SHAMT_W'(1);
                r_op   <= op;
                r_fill <= a[WIDTH-1];
            end else if (r_state == ST_SHIFT) begin
                r_work <= w_step_res;
                r_cnt  <= r_cnt - SHAMT_W'(1);
            end
            if (w_load) begin
                r_result  <= w_load_res;
                r_c       <= w_load_c;
                r_v       <= w_load_v;
                r_illegal <= w_load_ill;
                r_z       <= (w_load_res == '0);
                r_s       <= w_load_res[WIDTH-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Registered execute stage of the KGP-RISC datapath. It sits between the operand/decode stage and writeback.
- Accepts one ALU operation per handshake: two 32-bit operands, an opcode and a shift amount.
- Computes the result and flags, holding them in an output register until writeback takes them.
- Logic and add/sub ops complete in one cycle; shifts run iteratively, one bit per cycle.

Parameters:
- WIDTH, 32, operand/result width.
- SHAMT_W, 5, shift-amount width (log2 WIDTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  upstream presents an operation.
- in_ready  out  1  stage can accept; in_ready = (state==IDLE) | (state==HOLD & out_ready).
- op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(~a), 6 SLL, 7 SRL, 8 SRA; 9-15 illegal.
- a  in  WIDTH  operand A (shift source).
- b  in  WIDTH  operand B.
- shamt  in  SHAMT_W  shift amount; ignored for non-shift ops.
- out_valid  out  1  result register valid.
- out_ready  in  1  downstream takes result.
- result  out  WIDTH  registered result.
- flag_c  out  1  carry/borrow/last-bit-out.
- flag_z  out  1  result==0.
- flag_s  out  1  result[WIDTH-1].
- flag_v  out  1  signed overflow.
- illegal  out  1  op was illegal.
- busy  out  1  state==SHIFT.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - out_valid, result, all flags, illegal, busy and the internal counter are all 0.
  - Reset mid-shift or mid-hold discards the operation; no output is produced.
- Handshakes:
  - Accept = in_valid & in_ready at a rising edge. a, b, op and shamt are captured there; later input changes are ignored.
  - Output transfer = out_valid & out_ready. result and flags stay stable while out_valid=1 and out_ready=0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - On accept of a non-shift op, or a shift with shamt=0: compute, register result and flags, go to HOLD.
  - On accept of a shift with shamt=k≥1: load the work register with a shifted by 1 bit and cnt=k-1.
    - If k=1, go to HOLD with the final values.
    - Otherwise go to SHIFT.
  - SHIFT: in_ready=0, busy=1. Each edge shifts the work register 1 bit and decrements cnt. When cnt reaches 1, perform the last shift and go to HOLD.
  - HOLD: out_valid=1.
    - out_ready=1 with no accept: go to IDLE.
    - out_ready=1 with a simultaneous accept: take the new op as from IDLE (back-to-back, no bubble).
- Latency, counted in edges after the accept edge E0:
  - Non-shift ops and shamt=0: out_valid is high after E0.
  - Shift with k≥1: out_valid is high after E0+k-1.
  - Throughput for single-cycle ops: 1 per cycle while out_ready=1.
- Arithmetic (modulo 2^WIDTH):
  - ADD: flag_c = carry out of bit WIDTH-1; flag_v = (a[31]==b[31]) & (r[31]!=a[31]).
  - SUB (a-b): flag_c = borrow, i.e. 1 iff a<b unsigned; flag_v = (a[31]!=b[31]) & (r[31]!=a[31]).
  - AND/OR/XOR/NOT: flag_c=0, flag_v=0.
  - SLL/SRL: zero fill. SRA: fill with the original a[31].
  - Shifts: flag_c = last bit shifted out (0 when shamt=0); flag_v=0.
  - flag_z and flag_s are always derived from the registered result.
- Illegal op: completes in one cycle with result=0, flag_c=0, flag_v=0, flag_z=1, flag_s=0, illegal=1. illegal=0 for all legal ops.

Decomposition:
- Package kgp_alu_pkg:
  - opcode localparams (OP_ADD..OP_SRA);
  - state encoding IDLE/SHIFT/HOLD;
  - WIDTH and SHAMT_W defaults.
- Sub-module alu_addsub: combinational WIDTH-bit adder/subtractor producing sum, carry/borrow and overflow.
- Logic ops and shift step are inline.

Test Plan:
- ADD a=32'hFFFF_FFFF, b=1, out_ready=1 -> after 1 edge: result=0, c=1, z=1, v=0, s=0.
- SUB a=32'h8000_0000, b=1 -> result=32'h7FFF_FFFF, v=1, c=0. SUB a=3, b=5 -> result=32'hFFFF_FFFE, c=1, s=1.
- SRA a=32'h8000_00F0, shamt=4 -> busy high 3 cycles, in_ready=0; out_valid after E0+3; result=32'hF800_000F, c=0. SLL a=32'h8000_0001, shamt=1 -> result=2, c=1, no SHIFT state.
- Back-to-back: 4 AND/OR/XOR/NOT ops with in_valid=1, out_ready=1 -> 4 results on consecutive cycles. Then hold out_ready=0 for 3 cycles -> result stable, in_ready=0, next op accepted only when out_ready rises.
- op=4'hC -> illegal=1, result=0, z=1, 1-cycle latency. Next ADD -> illegal=0.
- Assert rst_n=0 mid-shift (SRL shamt=31, cycle 10) -> out_valid, busy, result go 0 immediately. After release, state IDLE, in_ready=1, no stale output.
